framebuffer_arbiter: RTL and testbench

Owns the single-port double-buffered framebuffer RAM that sits between the SPI pixel receiver (writer) and the HUB75 scan engine (reader). Arbitrates the one RAM port with the reader at fixed priority and queues writer words in a small FIFO. Tracks display and write banks, and swaps them tear-free at the end of a displayed frame, once a full frame has been written.

---
 rtl/framebuffer_arbiter.sv | 166 ++++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: owns the single RAM port of the double-buffered
// framebuffer. The scan-engine reader has fixed priority over writer words,
// which wait in a small FIFO. The display and write banks swap tear-free on
// frame_end once a complete frame has been committed.
// Optional build macro FB_STALL_COUNT_EN adds the stall_count output.
module framebuffer_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  frame_end,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  display_bank,
    output logic                  write_bank,
    output logic                  swap_pending
`ifdef FB_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;

    typedef enum logic {
        FILLING   = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fifo_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0]        fifo_head, fifo_tail;
    logic [PTR_W:0]          fifo_count;
    logic                    fifo_empty, fifo_full;
    logic                    push, do_commit, last_word, do_swap;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [1:0]              rd_pipe;

    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == (PTR_W+1)'(WFIFO_DEPTH));
    assign wr_ready     = !fifo_full;
    assign push         = wr_valid && wr_ready;
    // Reader always wins the port; writes also hold off while a finished
    // frame waits to be displayed, so the back bank is never overwritten.
    assign do_commit    = !rd_req && !fifo_empty && (state_q == FILLING);
    assign last_word    = do_commit && (wr_ptr == '1);
    assign swap_pending = (state_q == WAIT_SWAP);
    assign write_bank   = ~display_bank;

    // Next-state: frame completion and swap decision.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips an assignment infers a latch.
        state_d = state_q;
        do_swap = 1'b0;
        case (state_q)
            FILLING: begin
                if (last_word) begin
                    // A frame_end landing on the final commit swaps at once.
                    if (frame_end) do_swap = 1'b1;
                    else           state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (frame_end) begin
                    do_swap = 1'b1;
                    state_d = FILLING;
                end
            end
            default: state_d = FILLING;
        endcase
    end

    // State register and display bank; write_bank is its complement.
    always_ff @(posedge pixel_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= FILLING;
            display_bank <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_swap) display_bank <= ~display_bank;
        end
    end

    // FIFO storage.
    always_ff @(posedge pixel_clk) begin
        // NOTE: the storage array is not reset; the count marks which
        // entries are meaningful, and a reset RAM would cost a flop array.
        if (push) fifo_mem[fifo_tail] <= wr_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
        end else begin
            if (push)      fifo_tail <= fifo_tail + PTR_W'(1);
            if (do_commit) fifo_head <= fifo_head + PTR_W'(1);
            case ({push, do_commit})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // RAM port slot: read, write commit, or idle.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            wr_ptr      <= '0;
        end else if (rd_req) begin
            mem_addr  <= {display_bank, rd_addr};
            mem_wr_en <= 1'b0;
        end else if (do_commit) begin
            mem_addr    <= {write_bank, wr_ptr};
            mem_wr_data <= fifo_mem[fifo_head];
            mem_wr_en   <= 1'b1;
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
        end else begin
            mem_wr_en <= 1'b0;
        end
    end

    // Read return: address registered, RAM latency, then capture.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rd_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= {rd_pipe[0], rd_req};
            rd_valid <= rd_pipe[1];
            if (rd_pipe[1]) rd_data <= mem_rd_data;
        end
    end

`ifdef FB_STALL_COUNT_EN
    // Saturating count of cycles a queued word could not be committed.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!fifo_empty && !do_commit && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed bench for framebuffer_arbiter with a
// behavioural synchronous RAM, write/read scoreboards and a cycle table for
// the read/write contention window.
module tb_framebuffer_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          pixel_clk = 1'b0;
    logic          reset, wr_valid, rd_req, frame_end;
    logic          wr_ready, rd_valid, mem_wr_en;
    logic          display_bank, write_bank, swap_pending;
    logic [DW-1:0] wr_data, rd_data, mem_wr_data, mem_rd_data;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   mem_addr;
`ifdef FB_STALL_COUNT_EN
    logic [15:0]   stall_count;
`endif

    always #5 pixel_clk = ~pixel_clk;

    framebuffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WFIFO_DEPTH(4)) dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .frame_end    (frame_end),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .display_bank (display_bank),
        .write_bank   (write_bank),
        .swap_pending (swap_pending)
`ifdef FB_STALL_COUNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    // Single-port RAM, one-cycle synchronous read.
    logic [DW-1:0] ram [1 << (AW + 1)];
    always @(posedge pixel_clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    wr_exp_t       wq[$];
    logic [DW-1:0] rq[$];

    // Every RAM write must match the next expected {address, data}.
    always @(negedge pixel_clk) begin
        if (mem_wr_en) begin
            wr_exp_t e;
            check("write_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e.addr));
                check("write_data", mem_wr_data, e.data);
            end
        end
    end

    // Every returned read must match the next expected word.
    always @(negedge pixel_clk) begin
        if (rd_valid) begin
            logic [DW-1:0] d;
            check("read_expected", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
                d = rq.pop_front();
                check("read_data", rd_data, d);
            end
        end
    end

    task automatic tick();
        @(negedge pixel_clk);
    endtask

    task automatic idle(input int n);
        wr_valid  = 1'b0;
        rd_req    = 1'b0;
        frame_end = 1'b0;
        repeat (n) tick();
    endtask

    // Push n consecutive words, one per cycle, queuing the expected writes.
    task automatic push_stream(input int n, input logic [DW-1:0] base,
                               input logic bank, input logic [AW-1:0] start_ptr);
        logic [AW-1:0] p;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            p        = start_ptr + AW'(i);
            wq.push_back('{addr: {bank, p}, data: base + DW'(i)});
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_swap(input int budget);
        int k = 0;
        while (!swap_pending && k < budget) begin
            tick();
            k++;
        end
        check("swap_pending_set", 32'(swap_pending), 32'd1);
    endtask

    typedef struct {
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          wr_valid;
        logic [DW-1:0] wr_data;
        logic          exp_we;
        logic [AW:0]   exp_addr;
        logic          exp_ready;
        logic          exp_rv;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic rq_i, input logic [AW-1:0] ra, input logic wv,
                                input logic [DW-1:0] wd, input logic we, input logic [AW:0] ea,
                                input logic er, input logic ev);
        vec_t v;
        v.rd_req = rq_i; v.rd_addr = ra; v.wr_valid = wv; v.wr_data = wd;
        v.exp_we = we; v.exp_addr = ea; v.exp_ready = er; v.exp_rv = ev;
        return v;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << (AW + 1)); i++) ram[i] = '0;
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; frame_end = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_display_bank", 32'(display_bank), 32'd0);
        check("rst_write_bank",   32'(write_bank),   32'd1);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        check("rst_wr_ready",     32'(wr_ready),     32'd1);
        check("rst_mem_wr_en",    32'(mem_wr_en),    32'd0);
        check("rst_mem_addr",     32'(mem_addr),     32'd0);
        check("rst_mem_wr_data",  mem_wr_data,       32'd0);
        check("rst_rd_valid",     32'(rd_valid),     32'd0);
        check("rst_rd_data",      rd_data,           32'd0);
`ifdef FB_STALL_COUNT_EN
        check("rst_stall_count",  32'(stall_count),  32'd0);
`endif
        reset = 1'b0;

        // Full frame into bank 1, hold, then swap on frame_end.
        push_stream(2048, 32'h0, 1'b1, '0);
        wait_swap(8);
        idle(3);
        check("fill_wq_drained",  32'(wq.size()),    32'd0);
        check("fill_hold_swap",   32'(swap_pending), 32'd1);
        check("fill_hold_disp",   32'(display_bank), 32'd0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("swap1_display",    32'(display_bank), 32'd1);
        check("swap1_write",      32'(write_bank),   32'd0);
        check("swap1_pending",    32'(swap_pending), 32'd0);
        idle(2);

        // Contention: reads at 0..9 hold off 4 queued words, which then
        // commit to bank 0 starting at address 0.
        tbl[0]  = mk(1'b0, 11'd0, 1'b1, 32'h1000, 1'b0, 12'hFFF, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 11'd0, 1'b1, 32'h1001, 1'b0, 12'h800, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 11'd1, 1'b1, 32'h1002, 1'b0, 12'h801, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 11'd2, 1'b1, 32'h1003, 1'b0, 12'h802, 1'b0, 1'b1);
        for (int r = 4; r <= 10; r++)
            tbl[r] = mk(1'b1, AW'(r - 1), 1'b0, 32'h0, 1'b0, 12'h800 + 12'(r - 1), 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 11'd0, 1'b0, 32'h0, 1'b1, 12'h000, 1'b1, 1'b1);
        tbl[12] = mk(1'b0, 11'd0, 1'b0, 32'h0, 1'b1, 12'h001, 1'b1, 1'b1);
        tbl[13] = mk(1'b0, 11'd0, 1'b0, 32'h0, 1'b1, 12'h002, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 11'd0, 1'b0, 32'h0, 1'b1, 12'h003, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 11'd0, 1'b0, 32'h0, 1'b0, 12'h003, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            wq.push_back('{addr: 12'(k), data: 32'h1000 + 32'(k)});
        for (int r = 0; r < 16; r++) begin
            rd_req   = tbl[r].rd_req;
            rd_addr  = tbl[r].rd_addr;
            wr_valid = tbl[r].wr_valid;
            wr_data  = tbl[r].wr_data;
            if (tbl[r].rd_req) rq.push_back(32'(tbl[r].rd_addr));
            tick();
            check($sformatf("cont%0d_wr_en", r),    32'(mem_wr_en), 32'(tbl[r].exp_we));
            check($sformatf("cont%0d_addr", r),     32'(mem_addr),  32'(tbl[r].exp_addr));
            check($sformatf("cont%0d_wr_ready", r), 32'(wr_ready),  32'(tbl[r].exp_ready));
            check($sformatf("cont%0d_rd_valid", r), 32'(rd_valid),  32'(tbl[r].exp_rv));
        end
        idle(2);
        check("cont_rq_drained", 32'(rq.size()), 32'd0);
        check("cont_wq_drained", 32'(wq.size()), 32'd0);
`ifdef FB_STALL_COUNT_EN
        check("cont_stall_count", 32'(stall_count), 32'd10);
`endif

        // Backpressure: finish bank 0, fill the FIFO while the swap waits.
        push_stream(2044, 32'h2000, 1'b0, 11'd4);
        wait_swap(8);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h3000 + 32'(k);
            wq.push_back('{addr: {1'b1, AW'(k)}, data: 32'h3000 + 32'(k)});
            tick();
            check($sformatf("bp_ready%0d", k), 32'(wr_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        idle(3);
        check("bp_hold_swap",     32'(swap_pending), 32'd1);
        check("bp_hold_ready",    32'(wr_ready),     32'd0);
        check("bp_hold_wr_en",    32'(mem_wr_en),    32'd0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("bp_swap_display",  32'(display_bank), 32'd0);
        check("bp_swap_write",    32'(write_bank),   32'd1);
        check("bp_swap_pending",  32'(swap_pending), 32'd0);
        check("bp_swap_wr_en",    32'(mem_wr_en),    32'd0);
        tick();
        check("bp_first_wr_en",   32'(mem_wr_en),    32'd1);
        check("bp_first_addr",    32'(mem_addr),     32'h800);
        check("bp_ready_back",    32'(wr_ready),     32'd1);
        idle(5);
        check("bp_wq_drained",    32'(wq.size()),    32'd0);

        // Simultaneous final commit and frame_end.
        push_stream(2044, 32'h4000, 1'b1, 11'd4);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("sim_last_wr_en",   32'(mem_wr_en),    32'd1);
        check("sim_last_addr",    32'(mem_addr),     32'hFFF);
        check("sim_swap_pending", 32'(swap_pending), 32'd0);
        check("sim_display",      32'(display_bank), 32'd1);
        check("sim_write",        32'(write_bank),   32'd0);
        idle(3);
        check("sim_pending_low",  32'(swap_pending), 32'd0);
        check("sim_wq_drained",   32'(wq.size()),    32'd0);

        // Reset mid-frame with a word still queued.
        push_stream(1000, 32'h5000, 1'b0, '0);
        wr_valid = 1'b1; wr_data = 32'hDEAD; tick();
        wr_valid = 1'b0; reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("mid_wq_drained",   32'(wq.size()),    32'd0);
        check("mid_display",      32'(display_bank), 32'd0);
        check("mid_write",        32'(write_bank),   32'd1);
        check("mid_pending",      32'(swap_pending), 32'd0);
        check("mid_wr_ready",     32'(wr_ready),     32'd1);
        check("mid_rd_valid",     32'(rd_valid),     32'd0);
`ifdef FB_STALL_COUNT_EN
        check("mid_stall_count",  32'(stall_count),  32'd0);
`endif
        idle(4);
        check("mid_no_commit",    32'(mem_wr_en),    32'd0);
        push_stream(1, 32'h6000, 1'b1, '0);
        tick();
        check("mid_first_addr",   32'(mem_addr),     32'h800);
        idle(3);
        check("end_wq_drained",   32'(wq.size()),    32'd0);
        check("end_rq_drained",   32'(rq.size()),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
